// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Holds the FSM state enum, opcode classes and write-back mux encodings.
package mcu_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } mcu_state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILLEGAL
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] WB_ALU   = 3'd0;
  localparam logic [2:0] WB_MEM   = 3'd1;
  localparam logic [2:0] WB_LUI   = 3'd2;
  localparam logic [2:0] WB_AUIPC = 3'd3;
  localparam logic [2:0] WB_PC4   = 3'd4;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  function automatic instr_class_t decode_class(input logic [6:0] op);
    case (op)
      OP_R:      return C_R;
      OP_I:      return C_I;
      OP_LOAD:   return C_LOAD;
      OP_STORE:  return C_STORE;
      OP_BRANCH: return C_BRANCH;
      OP_LUI:    return C_LUI;
      OP_AUIPC:  return C_AUIPC;
      OP_JAL:    return C_JAL;
      OP_JALR:   return C_JALR;
      default:   return C_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mcu_wait_timer.sv
// Counts consecutive cycles spent waiting for a memory ready and flags expiry.
// A ready in the expiry cycle wins; LIMIT = 0 disables the timeout.
module mcu_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Leaving the waiting state clears the count, so every entry starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!active) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && active && !ready && (cnt == LAST);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/mem/writeback,
// drives datapath selects and enable pulses, counts retired instructions.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 16,
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_code,
  input  logic        i_ready,
  input  logic        d_ready,
  output logic        i_req,
  output logic        d_req,
  output logic        d_we,
  output logic        ir_en,
  output logic        pc_en,
  output logic        reg_wr_en,
  output logic [3:0]  ALU_Controls,
  output logic        ALUSrcMuxSel,
  output logic [2:0]  RAM2RegWSel,
  output logic        branch,
  output logic        JAL,
  output logic        JALR,
  output logic        illegal_instr,
  output logic        bus_err,
  output logic [31:0] instret,
  output mcu_state_t  state_dbg
);

  // Handshake: i_req/d_req stay high until the matching ready is seen in the
  // same cycle; the transfer completes on that clock edge and req drops after.

  mcu_state_t   state, state_next;
  instr_class_t cls;
  logic [2:0]   f3;
  logic         f7b5;
  logic [3:0]   alu_ctrl;
  logic         alu_src;
  logic         retire;
  logic         i_to, d_to;
  logic         unused_bits;

  assign cls         = decode_class(instr_code[6:0]);
  assign f3          = instr_code[14:12];
  assign f7b5        = instr_code[30];
  assign unused_bits = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};
  assign state_dbg   = state;

  mcu_wait_timer #(.LIMIT(IMEM_TIMEOUT)) u_imem_timer (
    .clk(clk), .rst(rst), .active(state == S_FETCH), .ready(i_ready), .expired(i_to)
  );

  mcu_wait_timer #(.LIMIT(DMEM_TIMEOUT)) u_dmem_timer (
    .clk(clk), .rst(rst), .active(state == S_MEM), .ready(d_ready), .expired(d_to)
  );

  always_comb begin
    alu_ctrl = 4'b0000;
    alu_src  = 1'b0;
    case (cls)
      C_R:              alu_ctrl = {f7b5, f3};
      C_I: begin
        alu_src  = 1'b1;
        alu_ctrl = (f3 == 3'b101) ? {f7b5, f3} : {1'b0, f3};
      end
      C_LOAD, C_STORE: begin
        alu_ctrl = ALU_ADD;
        alu_src  = 1'b1;
      end
      C_BRANCH:         alu_ctrl = {1'b0, f3};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    i_req        = 1'b0;
    d_req        = 1'b0;
    d_we         = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    reg_wr_en    = 1'b0;
    ALU_Controls = 4'b0000;
    ALUSrcMuxSel = 1'b0;
    RAM2RegWSel  = WB_ALU;
    branch       = 1'b0;
    JAL          = 1'b0;
    JALR         = 1'b0;
    retire       = 1'b0;
    case (state)
      S_FETCH: begin
        // Gated by rst so nothing is requested while reset holds the FSM here.
        if (rst) begin
          i_req = 1'b1;
          if (i_ready) begin
            ir_en      = 1'b1;
            state_next = S_DECODE;
          end else if (i_to) begin
            state_next = S_HALT;
          end
        end
      end
      S_DECODE: begin
        if (cls == C_ILLEGAL) begin
          pc_en      = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        ALU_Controls = alu_ctrl;
        ALUSrcMuxSel = alu_src;
        case (cls)
          C_BRANCH: begin
            branch     = 1'b1;
            pc_en      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          C_JAL, C_JALR: begin
            JAL         = (cls == C_JAL);
            JALR        = (cls == C_JALR);
            RAM2RegWSel = WB_PC4;
            reg_wr_en   = 1'b1;
            pc_en       = 1'b1;
            retire      = 1'b1;
            state_next  = S_FETCH;
          end
          C_LOAD, C_STORE: state_next = S_MEM;
          default:         state_next = S_WB;
        endcase
      end
      S_MEM: begin
        ALU_Controls = alu_ctrl;
        ALUSrcMuxSel = alu_src;
        d_req        = 1'b1;
        d_we         = (cls == C_STORE);
        if (d_ready) begin
          if (cls == C_STORE) begin
            pc_en      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (d_to) begin
          state_next = S_HALT;
        end
      end
      S_WB: begin
        ALU_Controls = alu_ctrl;
        ALUSrcMuxSel = alu_src;
        case (cls)
          C_LOAD:  RAM2RegWSel = WB_MEM;
          C_LUI:   RAM2RegWSel = WB_LUI;
          C_AUIPC: RAM2RegWSel = WB_AUIPC;
          default: RAM2RegWSel = WB_ALU;
        endcase
        reg_wr_en  = 1'b1;
        pc_en      = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret       <= '0;
      illegal_instr <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      if (retire) instret <= instret + 32'd1;
      if (state == S_DECODE && cls == C_ILLEGAL) illegal_instr <= 1'b1;
      if ((state == S_FETCH && i_to) || (state == S_MEM && d_to)) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: table of instructions with expected
// per-instruction signatures, plus hand sequences for timeout and reset.
module tb_multicycle_control_unit;
  import mcu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_code;
  logic        i_ready, d_ready;
  logic        i_req, d_req, d_we, ir_en, pc_en, reg_wr_en;
  logic [3:0]  ALU_Controls;
  logic        ALUSrcMuxSel;
  logic [2:0]  RAM2RegWSel;
  logic        branch, JAL, JALR, illegal_instr, bus_err;
  logic [31:0] instret;
  mcu_state_t  state_dbg;

  multicycle_control_unit #(.IMEM_TIMEOUT(16), .DMEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .instr_code(instr_code), .i_ready(i_ready), .d_ready(d_ready),
    .i_req(i_req), .d_req(d_req), .d_we(d_we), .ir_en(ir_en), .pc_en(pc_en),
    .reg_wr_en(reg_wr_en), .ALU_Controls(ALU_Controls), .ALUSrcMuxSel(ALUSrcMuxSel),
    .RAM2RegWSel(RAM2RegWSel), .branch(branch), .JAL(JAL), .JALR(JALR),
    .illegal_instr(illegal_instr), .bus_err(bus_err), .instret(instret), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [7:0] cycles;
    logic [7:0] dreq_cyc;
    logic       dwe;
    logic [3:0] alu;
    logic       src;
    logic [2:0] wbsel;
    logic       reg_wr;
    logic       br;
    logic       jal;
    logic       jalr;
  } obs_t;
  localparam int OW = $bits(obs_t);

  typedef struct {
    logic [31:0] instr;
    int          i_wait;
    int          d_wait;
    bit          retires;
    obs_t        exp;
  } vec_t;

  logic [OW-1:0] exp_q[$];
  vec_t          vecs[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [31:0]   exp_instret = '0;

  function automatic obs_t mk(int cyc, int dq, bit dwe, logic [3:0] alu, bit src,
                              logic [2:0] wb, bit rw, bit br, bit jal, bit jalr);
    obs_t o;
    o.cycles = 8'(cyc); o.dreq_cyc = 8'(dq); o.dwe = dwe; o.alu = alu; o.src = src;
    o.wbsel = wb; o.reg_wr = rw; o.br = br; o.jal = jal; o.jalr = jalr;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic apply_reset();
    rst = 1'b0; i_ready = 1'b0; d_ready = 1'b0; instr_code = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_i_req", 32'(i_req), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_FETCH));
    check("rst_flags", {instret[29:0], illegal_instr, bus_err}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rel_i_req", 32'(i_req), 32'd1);
    exp_instret = '0;
  endtask

  // Runs one instruction from the start of FETCH up to the final pc_en cycle.
  task automatic run_instr(input logic [31:0] instr, input int i_wait, input int d_wait,
                           output obs_t got, output bit done);
    int ireq_n = 0;
    int dreq_n = 0;
    got = '0;
    done = 1'b0;
    instr_code = instr;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      i_ready = 1'b0; d_ready = 1'b0;
      #1;
      i_ready = i_req && (ireq_n == i_wait);
      d_ready = d_req && (dreq_n == d_wait);
      if (i_req) ireq_n++;
      if (d_req) begin
        dreq_n++;
        got.dreq_cyc = got.dreq_cyc + 8'd1;
        if (d_we) got.dwe = 1'b1;
      end
      #1;
      if (pc_en) begin
        got.cycles = 8'(cyc + 1);
        got.alu = ALU_Controls; got.src = ALUSrcMuxSel; got.wbsel = RAM2RegWSel;
        got.reg_wr = reg_wr_en; got.br = branch; got.jal = JAL; got.jalr = JALR;
        done = 1'b1;
      end
    end
  endtask

  // scoreboard: push the expected signature, pop it when the DUT retires
  task automatic run_vec(input vec_t v);
    obs_t got, e;
    bit   done;
    exp_q.push_back(v.exp);
    run_instr(v.instr, v.i_wait, v.d_wait, got, done);
    e = obs_t'(exp_q.pop_front());
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout instr=0x%08h: no final pc_en within 100 cycles", v.instr);
      apply_reset();
      return;
    end
    if (got !== e) begin
      n_fail++;
      $display("FAIL instr=0x%08h: got cyc=%0d dreq=%0d dwe=%b alu=%b src=%b wb=%0d rw=%b br=%b jal=%b jalr=%b, expected cyc=%0d dreq=%0d dwe=%b alu=%b src=%b wb=%0d rw=%b br=%b jal=%b jalr=%b",
               v.instr, got.cycles, got.dreq_cyc, got.dwe, got.alu, got.src, got.wbsel,
               got.reg_wr, got.br, got.jal, got.jalr, e.cycles, e.dreq_cyc, e.dwe, e.alu,
               e.src, e.wbsel, e.reg_wr, e.br, e.jal, e.jalr);
    end
    @(posedge clk);
    #1;
    if (v.retires) exp_instret = exp_instret + 32'd1;
    check("instret", instret, exp_instret);
  endtask

  initial begin
    //                 instr        iw  dw ret   cyc dq we alu     src wb       rw br jal jalr
    vecs.push_back('{32'h002081B3,  0,  0, 1, mk( 4, 0, 0, 4'b0000, 0, WB_ALU,   1, 0, 0, 0)}); // ADD
    vecs.push_back('{32'h402081B3,  0,  0, 1, mk( 4, 0, 0, 4'b1000, 0, WB_ALU,   1, 0, 0, 0)}); // SUB
    vecs.push_back('{32'h0000A183,  0,  3, 1, mk( 8, 4, 0, 4'b0000, 1, WB_MEM,   1, 0, 0, 0)}); // LW
    vecs.push_back('{32'h0020A023,  0,  0, 1, mk( 4, 1, 1, 4'b0000, 1, WB_ALU,   0, 0, 0, 0)}); // SW
    vecs.push_back('{32'h00208463,  0,  0, 1, mk( 3, 0, 0, 4'b0000, 0, WB_ALU,   0, 1, 0, 0)}); // BEQ
    vecs.push_back('{32'h00209463,  0,  0, 1, mk( 3, 0, 0, 4'b0001, 0, WB_ALU,   0, 1, 0, 0)}); // BNE
    vecs.push_back('{32'h008000EF,  0,  0, 1, mk( 3, 0, 0, 4'b0000, 0, WB_PC4,   1, 0, 1, 0)}); // JAL
    vecs.push_back('{32'h000080E7,  0,  0, 1, mk( 3, 0, 0, 4'b0000, 0, WB_PC4,   1, 0, 0, 1)}); // JALR
    vecs.push_back('{32'h123450B7,  0,  0, 1, mk( 4, 0, 0, 4'b0000, 0, WB_LUI,   1, 0, 0, 0)}); // LUI
    vecs.push_back('{32'h00001097,  0,  0, 1, mk( 4, 0, 0, 4'b0000, 0, WB_AUIPC, 1, 0, 0, 0)}); // AUIPC
    vecs.push_back('{32'h00508093,  2,  0, 1, mk( 6, 0, 0, 4'b0000, 1, WB_ALU,   1, 0, 0, 0)}); // ADDI
    vecs.push_back('{32'h4030D093,  0,  0, 1, mk( 4, 0, 0, 4'b1101, 1, WB_ALU,   1, 0, 0, 0)}); // SRAI
    vecs.push_back('{32'h4000E093,  0,  0, 1, mk( 4, 0, 0, 4'b0110, 1, WB_ALU,   1, 0, 0, 0)}); // ORI bit30
    vecs.push_back('{32'h0020A023,  0,  2, 1, mk( 6, 3, 1, 4'b0000, 1, WB_ALU,   0, 0, 0, 0)}); // SW waits
    vecs.push_back('{32'h002081B3, 15,  0, 1, mk(19, 0, 0, 4'b0000, 0, WB_ALU,   1, 0, 0, 0)}); // ready at limit
    vecs.push_back('{32'h0000A183,  0, 15, 1, mk(20,16, 0, 4'b0000, 1, WB_MEM,   1, 0, 0, 0)}); // d at limit
    vecs.push_back('{32'h0000007F,  0,  0, 0, mk( 2, 0, 0, 4'b0000, 0, WB_ALU,   0, 0, 0, 0)}); // illegal

    apply_reset();
    check("flags_clear", {30'd0, illegal_instr, bus_err}, 32'd0);
    foreach (vecs[i]) run_vec(vecs[i]);
    check("illegal_set", 32'(illegal_instr), 32'd1);

    // Instruction memory never answers: HALT after 16 waiting cycles.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      i_ready = 1'b0; d_ready = 1'b0;
      #1;
      if (k == 15) begin
        check("to_last_state", 32'(state_dbg), 32'(S_FETCH));
        check("to_last_buserr", 32'(bus_err), 32'd0);
        check("to_last_ireq", 32'(i_req), 32'd1);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_ready = 1'b1; d_ready = 1'b1;
      #1;
      check("halt_state", 32'(state_dbg), 32'(S_HALT));
      check("halt_outputs", 32'({i_req, d_req, d_we, ir_en, pc_en, reg_wr_en, ALU_Controls,
                                 ALUSrcMuxSel, RAM2RegWSel, branch, JAL, JALR}), 32'd0);
    end
    check("halt_buserr", 32'(bus_err), 32'd1);
    check("halt_instret", instret, exp_instret);

    // Reset in the middle of a store's MEM phase.
    apply_reset();
    run_vec(vecs[0]);
    instr_code = 32'h0020A023;
    @(negedge clk); i_ready = 1'b1; d_ready = 1'b0;
    @(negedge clk); i_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mem_dreq", 32'({d_req, d_we}), 32'b11);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_pulses", 32'({d_req, d_we, pc_en, reg_wr_en, i_req}), 32'd0);
    check("rst_mid_state", 32'(state_dbg), 32'(S_FETCH));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ireq", 32'(i_req), 32'd1);
    check("rst_mid_instret", instret, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- FSM controller that sequences the RV32I datapath over several cycles per instruction, replacing single-cycle decode.
- Produces datapath selects (ALU_Controls, ALUSrcMuxSel, RAM2RegWSel, branch, JAL, JALR), write-enable pulses (pc_en, ir_en, reg_wr_en) and req/ready handshakes to instruction and data memory.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- IMEM_TIMEOUT, 16, max cycles to wait for i_ready before raising bus_err (0 disables the timeout)
- DMEM_TIMEOUT, 16, same limit for d_ready

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- instr_code  in  32  held instruction register contents (valid from DECODE onward)
- i_ready  in  1  instruction memory data valid; IR captures on ir_en
- d_ready  in  1  data memory access complete
- i_req  out  1  instruction fetch request
- d_req  out  1  data memory request
- d_we  out  1  data memory write (store); meaningful only with d_req
- ir_en  out  1  IR load pulse
- pc_en  out  1  PC update pulse
- reg_wr_en  out  1  register file write pulse
- ALU_Controls  out  4  ALU operation
- ALUSrcMuxSel  out  1  0: rs2, 1: immediate
- RAM2RegWSel  out  3  0 ALU, 1 dRdata, 2 LUI imm, 3 PC+imm, 4 PC+4
- branch, JAL, JALR  out  1 each  PC-mux qualifiers
- illegal_instr  out  1  sticky, set on unknown opcode
- bus_err  out  1  sticky, set on memory timeout
- instret  out  32  retired-instruction counter

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT. Reset → FETCH, instret=0, sticky flags=0.
- In FETCH with rst deasserted, i_req=1. All other outputs are 0 in every state unless listed below.
- FETCH: hold i_req=1 until i_ready. On i_ready, pulse ir_en and go to DECODE.
- DECODE: one cycle, no enables. Opcode classes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
  - Any other opcode: set illegal_instr, pulse pc_en with branch/JAL/JALR=0 (PC+4), do not increment instret, go to FETCH.
- EXECUTE: drive ALU selects.
  - R: ALU_Controls={funct7[5],funct3}, ALUSrc=0.
  - I-ALU: ALUSrc=1; ALU_Controls={funct7[5],funct3} when funct3=101, else {0,funct3}.
  - LOAD/STORE: ALU_Controls=0000 (ADD), ALUSrc=1.
  - BRANCH: ALU_Controls={0,funct3}, ALUSrc=0, branch=1, pulse pc_en, retire, go to FETCH.
  - JAL/JALR: assert JAL or JALR, RAM2RegWSel=4, pulse reg_wr_en and pc_en, retire, go to FETCH.
  - R, I-ALU, LUI, AUIPC go to WB. LOAD and STORE go to MEM.
- MEM: hold EXECUTE selects, d_req=1, d_we=1 for STORE. Wait for d_ready.
  - STORE: retire, pulse pc_en, go to FETCH.
  - LOAD: go to WB.
- WB: RAM2RegWSel = 0 (R/I), 1 (LOAD), 2 (LUI), 3 (AUIPC).
  - Hold ALU selects; AUIPC drives JALR=0.
  - Pulse reg_wr_en and pc_en (PC+4), retire, go to FETCH.
- Latency, zero wait: BRANCH/JAL/JALR 3 cycles; R/I/LUI/AUIPC/STORE 4; LOAD 5. Each memory wait cycle adds 1.
- Retire: instret += 1 on the cycle of the final pc_en; wraps 0xFFFFFFFF→0.
- Timeout: a wait counter resets on entry to FETCH/MEM. When it reaches the limit without ready: set bus_err, go to HALT.
- HALT: all outputs 0, exits only by reset.
- Ready timing: a ready arriving in the same cycle the counter reaches the limit wins; no error is raised.
- Ready outside FETCH/MEM is ignored.
- Reset mid-instruction: immediate return to FETCH, all pulses drop asynchronously, no partial write.
- pc_en, ir_en and reg_wr_en are never high for more than one consecutive cycle.

Decomposition:
- Shared package mcu_pkg:
  - state enum
  - opcode localparams
  - RAM2RegWSel encodings (WB_ALU, WB_MEM, WB_LUI, WB_AUIPC, WB_PC4)
  - ALU_ADD constant
- Sub-module mcu_wait_timer holds the wait counter and timeout compare, parameterised by limit.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), i_ready on the first FETCH cycle → ir_en at cycle 0, ALU_Controls=0000 in EXECUTE, reg_wr_en+pc_en with RAM2RegWSel=0 at cycle 3, instret=1.
- LW (0x0000A183) with d_ready delayed 3 cycles → d_req high 4 cycles with d_we=0; WB at cycle 7 with RAM2RegWSel=1; total 8 cycles.
- BEQ (0x00208463) → branch=1, ALU_Controls=0000, pc_en at cycle 2, no reg_wr_en.
- JALR (0x000080E7) → JALR=1, RAM2RegWSel=4, reg_wr_en and pc_en together at cycle 2.
- Opcode 0x7F, then i_ready held low 16 cycles → illegal_instr=1, instret unchanged, PC+4 pulse; then bus_err=1, state HALT, all outputs 0 until rst low.
- rst asserted mid-MEM of a store → d_req/d_we drop immediately; after release, i_req=1 in FETCH and instret=0.
